// File: rtl/frontend_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// frontend_pipe_ctrl
//
// Purpose:
//   Stall/flush controller for the in-order front end (PC, IF->ID, ID->RR,
//   RR->DP). It handles backend back-pressure and icache-miss bubbles. After
//   a backend redirect it runs a FLUSH -> RECOVER sequence, and a watchdog
//   flags a rename-map restore that never completes.
//
// Parameters:
//   FLUSH_CYCLES     cycles of forced clear after a redirect (1..15)
//   RECOVER_TIMEOUT  RECOVER cycles before the watchdog fires (2..255)
//
// Ports:
//   clock            sole clock, rising edge
//   reset            synchronous, active-low reset
//   dp_full          dispatch queue cannot accept a rename group
//   rob_full         ROB cannot accept a rename group
//   icache_miss      fetch has no valid group this cycle
//   redirect_valid   mispredict/exception redirect pulse
//   recover_done     rename map restore complete pulse
//   pc_stall         hold the PC register
//   stall_*/clear_*  hold/flush controls for the three pipeline registers
//   busy             controller is not in RUN
//   recover_timeout  sticky watchdog error, cleared only by reset
//   perf_stall_cnt   saturating count of pc_stall cycles
//   perf_flush_cnt   saturating count of FLUSH/redirect cycles
//
// Configuration:
//   FRONTEND_PERF_CNT_EN  when defined, the performance counters are built.
//                         Otherwise both counter ports are tied to zero.
// ---------------------------------------------------------------------------
module frontend_pipe_ctrl #(
    parameter int unsigned FLUSH_CYCLES    = 2,
    parameter int unsigned RECOVER_TIMEOUT = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        dp_full,
    input  logic        rob_full,
    input  logic        icache_miss,
    input  logic        redirect_valid,
    input  logic        recover_done,
    output logic        pc_stall,
    output logic        stall_if_id,
    output logic        clear_if_id,
    output logic        stall_id_rr,
    output logic        clear_id_rr,
    output logic        stall_rr_dp,
    output logic        clear_rr_dp,
    output logic        busy,
    output logic        recover_timeout,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        FLUSH   = 2'd1,
        RECOVER = 2'd2
    } state_e;

    localparam logic [3:0] FLUSH_LOAD  = 4'(FLUSH_CYCLES - 1);
    localparam logic [8:0] TIMEOUT_VAL = 9'(RECOVER_TIMEOUT);

    state_e     state_q, state_d;
    logic [3:0] flushCnt_q, flushCnt_d;
    logic [7:0] recCnt_q, recCnt_d;
    logic       doneLatch_q, doneLatch_d;
    logic       timeout_q, timeout_d;
    logic       backendStall;

    assign backendStall    = dp_full | rob_full;
    assign busy            = (state_q != RUN);
    assign recover_timeout = timeout_q;

    // Output decode. A redirect overrides everything. Clearing all three
    // registers while letting the PC load the redirect target means we never
    // stall and clear the same register together.
    always_comb begin
        pc_stall    = 1'b0;
        stall_if_id = 1'b0;
        clear_if_id = 1'b0;
        stall_id_rr = 1'b0;
        clear_id_rr = 1'b0;
        stall_rr_dp = 1'b0;
        clear_rr_dp = 1'b0;
        if (redirect_valid) begin
            clear_if_id = 1'b1;
            clear_id_rr = 1'b1;
            clear_rr_dp = 1'b1;
        end else begin
            case (state_q)
                RUN: begin
                    if (backendStall) begin
                        pc_stall    = 1'b1;
                        stall_if_id = 1'b1;
                        stall_id_rr = 1'b1;
                        stall_rr_dp = 1'b1;
                    end else if (icache_miss) begin
                        // Bubble: hold PC, inject an empty group into IF->ID.
                        pc_stall    = 1'b1;
                        clear_if_id = 1'b1;
                    end
                end
                FLUSH: begin
                    pc_stall    = 1'b1;
                    clear_if_id = 1'b1;
                    clear_id_rr = 1'b1;
                    clear_rr_dp = 1'b1;
                end
                RECOVER: begin
                    // Hold the already-fetched correct-path groups upstream
                    // and keep dispatch starved until the map is restored.
                    pc_stall    = 1'b1;
                    stall_if_id = 1'b1;
                    stall_id_rr = 1'b1;
                    clear_rr_dp = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Next-state logic. An early recover_done seen during FLUSH is
    // remembered so that RECOVER lasts only one cycle.
    always_comb begin
        state_d     = state_q;
        flushCnt_d  = flushCnt_q;
        recCnt_d    = recCnt_q;
        doneLatch_d = doneLatch_q;
        timeout_d   = timeout_q;
        if (redirect_valid) begin
            state_d     = FLUSH;
            flushCnt_d  = FLUSH_LOAD;
            recCnt_d    = 8'd0;
            doneLatch_d = 1'b0;
        end else begin
            case (state_q)
                FLUSH: begin
                    if (recover_done) begin
                        doneLatch_d = 1'b1;
                    end
                    if (flushCnt_q == 4'd0) begin
                        state_d = RECOVER;
                    end else begin
                        flushCnt_d = flushCnt_q - 4'd1;
                    end
                end
                RECOVER: begin
                    if (recCnt_q != 8'hFF) begin
                        recCnt_d = recCnt_q + 8'd1;
                    end
                    // Fires on the edge where the counter reaches the limit.
                    if ((9'(recCnt_q) + 9'd1) >= TIMEOUT_VAL) begin
                        timeout_d = 1'b1;
                    end
                    if (recover_done || doneLatch_q) begin
                        state_d     = RUN;
                        doneLatch_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= RUN;
            flushCnt_q  <= 4'd0;
            recCnt_q    <= 8'd0;
            doneLatch_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            flushCnt_q  <= flushCnt_d;
            recCnt_q    <= recCnt_d;
            doneLatch_q <= doneLatch_d;
            timeout_q   <= timeout_d;
        end
    end

`ifdef FRONTEND_PERF_CNT_EN
    logic [31:0] perfStall_q;
    logic [31:0] perfFlush_q;

    // Saturating performance counters.
    always_ff @(posedge clock) begin
        if (!reset) begin
            perfStall_q <= 32'd0;
            perfFlush_q <= 32'd0;
        end else begin
            if (pc_stall && (perfStall_q != 32'hFFFF_FFFF)) begin
                perfStall_q <= perfStall_q + 32'd1;
            end
            if (((state_q == FLUSH) || redirect_valid) && (perfFlush_q != 32'hFFFF_FFFF)) begin
                perfFlush_q <= perfFlush_q + 32'd1;
            end
        end
    end

    assign perf_stall_cnt = perfStall_q;
    assign perf_flush_cnt = perfFlush_q;
`else
    assign perf_stall_cnt = 32'd0;
    assign perf_flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_frontend_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// tb_frontend_pipe_ctrl
//
// Drives frontend_pipe_ctrl (FLUSH_CYCLES=2, RECOVER_TIMEOUT=4) with directed
// scenarios and random traffic. Every cycle, the outputs are compared with a
// behavioural model that tracks the controller phase, the flush cycles still
// to go, the cycles spent recovering, whether restore completion was already
// seen, and the counts the performance counters should hold.
// ---------------------------------------------------------------------------
module tb_frontend_pipe_ctrl;

    localparam int FC = 2;
    localparam int RT = 4;
`ifdef FRONTEND_PERF_CNT_EN
    localparam bit PERF_EN = 1'b1;
`else
    localparam bit PERF_EN = 1'b0;
`endif

    localparam int PH_RUN     = 0;
    localparam int PH_FLUSH   = 1;
    localparam int PH_RECOVER = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic        dp_full, rob_full, icache_miss, redirect_valid, recover_done;
    logic        pc_stall, stall_if_id, clear_if_id, stall_id_rr, clear_id_rr;
    logic        stall_rr_dp, clear_rr_dp, busy, recover_timeout;
    logic [31:0] perf_stall_cnt, perf_flush_cnt;
    logic [8:0]  outVec;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    int     mPhase;
    int     mFlushLeft;
    int     mRecCycles;
    bit     mDoneSeen;
    bit     mTimeout;
    longint mPerfStall;
    longint mPerfFlush;

    frontend_pipe_ctrl #(.FLUSH_CYCLES(FC), .RECOVER_TIMEOUT(RT)) dut (
        .clock(clock), .reset(reset),
        .dp_full(dp_full), .rob_full(rob_full), .icache_miss(icache_miss),
        .redirect_valid(redirect_valid), .recover_done(recover_done),
        .pc_stall(pc_stall),
        .stall_if_id(stall_if_id), .clear_if_id(clear_if_id),
        .stall_id_rr(stall_id_rr), .clear_id_rr(clear_id_rr),
        .stall_rr_dp(stall_rr_dp), .clear_rr_dp(clear_rr_dp),
        .busy(busy), .recover_timeout(recover_timeout),
        .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
    );

    assign outVec = {pc_stall, stall_if_id, clear_if_id, stall_id_rr, clear_id_rr,
                     stall_rr_dp, clear_rr_dp, busy, recover_timeout};

    always #5 clock = ~clock;

    function automatic void modelReset();
        mPhase     = PH_RUN;
        mFlushLeft = 0;
        mRecCycles = 0;
        mDoneSeen  = 1'b0;
        mTimeout   = 1'b0;
        mPerfStall = 0;
        mPerfFlush = 0;
    endfunction

    // Expected outputs, taken directly from the behaviour table for each phase
    function automatic logic [8:0] modelOut();
        logic ps, sIf, cIf, sId, cId, sRr, cRr;
        {ps, sIf, cIf, sId, cId, sRr, cRr} = 7'b0;
        if (redirect_valid) begin
            {cIf, cId, cRr} = 3'b111;
        end else if (mPhase == PH_FLUSH) begin
            {ps, cIf, cId, cRr} = 4'b1111;
        end else if (mPhase == PH_RECOVER) begin
            {ps, sIf, sId, cRr} = 4'b1111;
        end else if (dp_full || rob_full) begin
            {ps, sIf, sId, sRr} = 4'b1111;
        end else if (icache_miss) begin
            {ps, cIf} = 2'b11;
        end
        return {ps, sIf, cIf, sId, cId, sRr, cRr, (mPhase != PH_RUN), mTimeout};
    endfunction

    function automatic logic [31:0] expPerf(input longint v);
        if (!PERF_EN) return 32'd0;
        if (v > 64'h0000_0000_FFFF_FFFF) return 32'hFFFF_FFFF;
        return v[31:0];
    endfunction

    // Advance the model across one rising edge using the inputs held now
    function automatic void modelAdvance();
        logic [8:0] o;
        if (!reset) begin
            modelReset();
            return;
        end
        o = modelOut();
        if (o[8]) mPerfStall++;
        if (mPhase == PH_FLUSH || redirect_valid) mPerfFlush++;
        if (redirect_valid) begin
            mPhase     = PH_FLUSH;
            mFlushLeft = FC;
            mRecCycles = 0;
            mDoneSeen  = 1'b0;
        end else if (mPhase == PH_FLUSH) begin
            if (recover_done) mDoneSeen = 1'b1;
            mFlushLeft--;
            if (mFlushLeft == 0) mPhase = PH_RECOVER;
        end else if (mPhase == PH_RECOVER) begin
            mRecCycles++;
            if (mRecCycles >= RT) mTimeout = 1'b1;
            if (recover_done || mDoneSeen) begin
                mPhase    = PH_RUN;
                mDoneSeen = 1'b0;
            end
        end
    endfunction

    task automatic applyStimulus(input logic rstN, input logic dp, input logic rob,
                                 input logic ic, input logic rd, input logic rdone);
        reset          = rstN;
        dp_full        = dp;
        rob_full       = rob;
        icache_miss    = ic;
        redirect_valid = rd;
        recover_done   = rdone;
    endtask

    task automatic test_reset();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clock);
        modelReset();
        @(negedge clock);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, i[0], 1'b0, i[1], 1'b0, 1'b0);
            #1;
            vectors++;
            if (outVec !== modelOut()) begin
                miscompares++;
                $display("[TB] FAIL reset_outputs cyc %0d got %b expected %b", i, outVec, modelOut());
            end
            vectors++;
            if (perf_stall_cnt !== 32'd0 || perf_flush_cnt !== 32'd0) begin
                miscompares++;
                $display("[TB] FAIL reset_perf got %0d/%0d expected 0/0", perf_stall_cnt, perf_flush_cnt);
            end
            @(posedge clock); modelAdvance(); @(negedge clock);
        end
    endtask

    task automatic test_backend_stall();
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, (i >= 1 && i <= 3), 1'b0, 1'b0, 1'b0, 1'b0);
            #1;
            vectors++;
            if (outVec !== modelOut()) begin
                miscompares++;
                $display("[TB] FAIL backend_stall cyc %0d got %b expected %b", i, outVec, modelOut());
            end
            vectors++;
            if (perf_stall_cnt !== expPerf(mPerfStall)) begin
                miscompares++;
                $display("[TB] FAIL backend_stall_perf cyc %0d got %0d expected %0d", i, perf_stall_cnt, expPerf(mPerfStall));
            end
            @(posedge clock); modelAdvance(); @(negedge clock);
        end
    endtask

    task automatic test_icache_under_stall();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, (i < 2), 1'b1, 1'b0, 1'b0);
            #1;
            vectors++;
            if (outVec !== modelOut()) begin
                miscompares++;
                $display("[TB] FAIL icache_under_stall cyc %0d got %b expected %b", i, outVec, modelOut());
            end
            vectors++;
            if ({stall_if_id, clear_if_id} !== ((i < 2) ? 2'b10 : 2'b01)) begin
                miscompares++;
                $display("[TB] FAIL icache_if_id cyc %0d got %b%b", i, stall_if_id, clear_if_id);
            end
            @(posedge clock); modelAdvance(); @(negedge clock);
        end
    endtask

    task automatic test_redirect_recover();
        logic [7:0] busyExp;
        busyExp = 8'b0011_1110;   // bit n = busy in cycle n: cycles 1..5
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, (i == 0), (i == 5));
            #1;
            vectors++;
            if (outVec !== modelOut()) begin
                miscompares++;
                $display("[TB] FAIL redirect_recover cyc %0d got %b expected %b", i, outVec, modelOut());
            end
            vectors++;
            if (busy !== busyExp[i]) begin
                miscompares++;
                $display("[TB] FAIL redirect_busy cyc %0d got %b expected %b", i, busy, busyExp[i]);
            end
            vectors++;
            if (perf_flush_cnt !== expPerf(mPerfFlush)) begin
                miscompares++;
                $display("[TB] FAIL redirect_perf cyc %0d got %0d expected %0d", i, perf_flush_cnt, expPerf(mPerfFlush));
            end
            @(posedge clock); modelAdvance(); @(negedge clock);
        end
    endtask

    task automatic test_early_recover();
        logic [5:0] recExp;
        recExp = 6'b00_1000;     // RECOVER outputs only in cycle 3
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, (i == 0), (i == 1));
            #1;
            vectors++;
            if (outVec !== modelOut()) begin
                miscompares++;
                $display("[TB] FAIL early_recover cyc %0d got %b expected %b", i, outVec, modelOut());
            end
            vectors++;
            if ((stall_if_id && busy) !== recExp[i]) begin
                miscompares++;
                $display("[TB] FAIL early_recover_phase cyc %0d got %b expected %b", i, stall_if_id && busy, recExp[i]);
            end
            @(posedge clock); modelAdvance(); @(negedge clock);
        end
    endtask

    task automatic test_watchdog();
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, (i == 0 || i == 9), 1'b0);
            #1;
            vectors++;
            if (outVec !== modelOut()) begin
                miscompares++;
                $display("[TB] FAIL watchdog cyc %0d got %b expected %b", i, outVec, modelOut());
            end
            vectors++;
            if (recover_timeout !== (i >= 7)) begin
                miscompares++;
                $display("[TB] FAIL watchdog_flag cyc %0d got %b expected %b", i, recover_timeout, (i >= 7));
            end
            @(posedge clock); modelAdvance(); @(negedge clock);
        end
    endtask

    task automatic test_reset_mid_flush();
        for (int i = 0; i < 4; i++) begin
            applyStimulus((i != 1), 1'b0, 1'b0, 1'b0, (i == 0), 1'b0);
            #1;
            vectors++;
            if (outVec !== modelOut()) begin
                miscompares++;
                $display("[TB] FAIL reset_mid_flush cyc %0d got %b expected %b", i, outVec, modelOut());
            end
            if (i == 2) begin
                vectors++;
                if (outVec !== 9'b0 || perf_stall_cnt !== 32'd0 || perf_flush_cnt !== 32'd0) begin
                    miscompares++;
                    $display("[TB] FAIL reset_mid_flush_clean got %b perf %0d/%0d expected all 0", outVec, perf_stall_cnt, perf_flush_cnt);
                end
            end
            @(posedge clock); modelAdvance(); @(negedge clock);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            applyStimulus(($urandom_range(0, 99) != 0),
                          ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
                          ($urandom_range(0, 3) == 0), ($urandom_range(0, 11) == 0),
                          ($urandom_range(0, 5) == 0));
            #1;
            vectors++;
            if (outVec !== modelOut()) begin
                miscompares++;
                $display("[TB] FAIL random cyc %0d got %b expected %b", i, outVec, modelOut());
            end
            vectors++;
            if ({perf_stall_cnt, perf_flush_cnt} !== {expPerf(mPerfStall), expPerf(mPerfFlush)}) begin
                miscompares++;
                $display("[TB] FAIL random_perf cyc %0d got %0d/%0d expected %0d/%0d", i,
                         perf_stall_cnt, perf_flush_cnt, expPerf(mPerfStall), expPerf(mPerfFlush));
            end
            vectors++;
            if ((stall_if_id & clear_if_id) | (stall_id_rr & clear_id_rr) | (stall_rr_dp & clear_rr_dp)) begin
                miscompares++;
                $display("[TB] FAIL random_stall_clear_overlap cyc %0d got %b expected no overlap", i, outVec);
            end
            @(posedge clock); modelAdvance(); @(negedge clock);
        end
    endtask

    initial begin
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        modelReset();
        test_reset();
        test_backend_stall();
        test_icache_under_stall();
        test_redirect_recover();
        test_early_recover();
        test_watchdog();
        test_reset_mid_flush();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
